// File: rtl/hex_entry_pkg.sv
// Shared types and sizing for the front-panel hex entry path.
package hex_entry_pkg;

  typedef enum logic {ENTRY, OFFER} state_e;

  localparam int unsigned NIBBLES = 8;
  localparam int unsigned NCNT_W  = 4;

endpackage

// File: rtl/hex_entry_capture_debounce.sv
// One push button: 2-flop synchroniser, stability counter, accepted level and
// a single-cycle pulse on each accepted press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // level accepted; only the 0->1 acceptance produces a pulse
        stable_q <= sync2_q;
        pulse_q  <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/hex_entry_capture.sv
// Front-panel hex entry: switches + ENTER build a 32-bit word, SEND offers it
// to the core over valid/ready; the live word is exported for the display.
module hex_entry_capture
  import hex_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic        btn_send,
  output logic [31:0] preview,
  output logic [3:0]  nibble_count,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready
);

  localparam logic [NCNT_W-1:0] CNT_FULL = NCNT_W'(NIBBLES);

  logic [3:0]        sw_meta_q;
  logic [3:0]        sw_sync_q;
  logic              enter_p;
  logic              clear_p;
  logic              send_p;
  state_e            state_q;
  logic [31:0]       acc_q;
  logic [NCNT_W-1:0] cnt_q;
  logic [31:0]       out_q;
  logic              valid_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clk(clk), .rst(rst), .btn_i(btn_enter), .pulse_o(enter_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clk(clk), .rst(rst), .btn_i(btn_clear), .pulse_o(clear_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_send (
    .clk(clk), .rst(rst), .btn_i(btn_send), .pulse_o(send_p)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENTRY;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ENTRY: begin
          // clear beats send beats enter; lower-priority pulses are dropped
          if (clear_p) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (send_p && (cnt_q != '0)) begin
            out_q   <= acc_q;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end else if (enter_p && !send_p) begin
            acc_q <= {acc_q[27:0], sw_sync_q};
            if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
          end
        end
        OFFER: begin
          if (data_ready) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ENTRY;
          end
        end
        default: state_q <= ENTRY;
      endcase
    end
  end

  assign preview      = acc_q;
  assign nibble_count = cnt_q;
  assign data_out     = out_q;
  assign data_valid   = valid_q;

endmodule

// File: tb/tb_hex_entry_capture.sv
// Directed and randomized bench for hex_entry_capture with a word-level model.
module tb_hex_entry_capture;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw;
  logic        btn_enter, btn_clear, btn_send;
  logic [31:0] preview;
  logic [3:0]  nibble_count;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;

  int checks   = 0;
  int failures = 0;
  int valid_cycles = 0;

  logic [31:0] m_acc;
  int          m_cnt;
  logic [31:0] m_out;

  hex_entry_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .btn_send(btn_send),
    .preview(preview), .nibble_count(nibble_count),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_valid === 1'b1) valid_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_enter(input logic [3:0] v);
    m_acc = m_acc * 32'd16 + 32'(v);
    m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
  endtask

  task automatic m_clear();
    m_acc = '0;
    m_cnt = 0;
  endtask

  task automatic check_state(input string tag, input logic exp_valid);
    check({tag, ".preview"}, preview, m_acc);
    check({tag, ".count"}, 32'(nibble_count), 32'(m_cnt));
    check({tag, ".valid"}, 32'(data_valid), 32'(exp_valid));
  endtask

  // clean press held well past the debounce window, then a clean release
  task automatic press(input logic e, input logic c, input logic s);
    btn_enter = e; btn_clear = c; btn_send = s;
    cyc(D + 4);
    btn_enter = 1'b0; btn_clear = 1'b0; btn_send = 1'b0;
    cyc(D + 4);
  endtask

  task automatic enter_nib(input logic [3:0] v);
    sw = v;
    press(1'b1, 1'b0, 1'b0);
    m_enter(v);
  endtask

  initial begin
    int base;
    logic [3:0] v;
    rst = 1'b0; sw = '0; data_ready = 1'b0;
    btn_enter = 1'b0; btn_clear = 1'b0; btn_send = 1'b0;
    m_acc = '0; m_cnt = 0; m_out = '0;
    cyc(3);
    check("reset.preview", preview, 32'h0);
    check("reset.count", 32'(nibble_count), 32'h0);
    check("reset.data_out", data_out, 32'h0);
    check("reset.valid", 32'(data_valid), 32'h0);
    rst = 1'b1;
    cyc(2);

    // first press: exact latency of the count update
    sw = 4'hA;
    btn_enter = 1'b1;
    repeat (D + 2) @(posedge clk);
    #1 check("latency.before", 32'(nibble_count), 32'h0);
    @(posedge clk);
    #1 check("latency.count", 32'(nibble_count), 32'h1);
    check("latency.preview", preview, 32'h0000000A);
    m_enter(4'hA);
    cyc(3);
    btn_enter = 1'b0;
    cyc(10);
    check_state("release", 1'b0);

    // bounce then hold: exactly one accepted press
    repeat (2) begin
      btn_enter = 1'b1; cyc(2);
      btn_enter = 1'b0; cyc(2);
    end
    check_state("bounce.during", 1'b0);
    btn_enter = 1'b1; cyc(10);
    m_enter(4'hA);
    btn_enter = 1'b0; cyc(10);
    check_state("bounce.hold", 1'b0);

    // glitch one cycle shorter than the debounce window
    btn_enter = 1'b1; cyc(D - 1);
    btn_enter = 1'b0; cyc(10);
    check_state("glitch", 1'b0);

    // full word then overflow
    press(1'b0, 1'b1, 1'b0); m_clear();
    for (int i = 1; i <= 8; i++) enter_nib(4'(i));
    check("word8.preview", preview, 32'h12345678);
    check("word8.count", 32'(nibble_count), 32'h8);
    enter_nib(4'h9);
    check("word9.preview", preview, 32'h23456789);
    check("word9.count", 32'(nibble_count), 32'h8);

    // handshake with a stalled core
    press(1'b0, 1'b1, 1'b0); m_clear();
    enter_nib(4'hD); enter_nib(4'hE); enter_nib(4'hF);
    press(1'b0, 1'b0, 1'b1);
    check("offer.valid", 32'(data_valid), 32'h1);
    check("offer.data", data_out, 32'h00000DEF);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("offer.hold", {31'b0, data_valid} ^ 32'h1 | (data_out ^ 32'h00000DEF), 32'h0);
    end
    sw = 4'h1;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check_state("offer.ignore", 1'b1);
    check("offer.ignore.data", data_out, 32'h00000DEF);
    data_ready = 1'b1;
    @(posedge clk);
    #1 m_clear();
    check_state("accept", 1'b0);
    check("accept.data", data_out, 32'h00000DEF);
    data_ready = 1'b0;
    cyc(2);

    // core already ready on offer entry: valid for exactly one cycle
    enter_nib(4'h7);
    data_ready = 1'b1;
    base = valid_cycles;
    press(1'b0, 1'b0, 1'b1);
    m_clear();
    check("oneshot.cycles", 32'(valid_cycles - base), 32'h1);
    check("oneshot.data", data_out, 32'h00000007);
    check_state("oneshot", 1'b0);
    data_ready = 1'b0;

    // priority: clear over enter, send over enter; empty send ignored
    enter_nib(4'h5);
    sw = 4'h6;
    press(1'b1, 1'b1, 1'b0); m_clear();
    check_state("prio.clear", 1'b0);
    enter_nib(4'h3);
    sw = 4'h4;
    press(1'b1, 1'b0, 1'b1);
    check_state("prio.send", 1'b1);
    check("prio.send.data", data_out, 32'h00000003);
    data_ready = 1'b1; cyc(2); data_ready = 1'b0;
    m_clear();
    press(1'b0, 1'b0, 1'b1);
    check_state("empty.send", 1'b0);
    m_out = 32'h00000003;

    // randomized operation mix against the model
    for (int n = 0; n < 40; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        press(1'b0, 1'b1, 1'b0); m_clear();
        check_state("rnd.clear", 1'b0);
      end else if (op == 1) begin
        if (m_cnt == 0) begin
          press(1'b0, 1'b0, 1'b1);
          check_state("rnd.empty", 1'b0);
        end else if ($urandom_range(0, 1) == 0) begin
          m_out = m_acc;
          data_ready = 1'b1;
          base = valid_cycles;
          press(1'b0, 1'b0, 1'b1);
          m_clear();
          check("rnd.oneshot.cycles", 32'(valid_cycles - base), 32'h1);
          check("rnd.oneshot.data", data_out, m_out);
          check_state("rnd.oneshot", 1'b0);
          data_ready = 1'b0;
        end else begin
          m_out = m_acc;
          press(1'b0, 1'b0, 1'b1);
          check_state("rnd.offer", 1'b1);
          check("rnd.offer.data", data_out, m_out);
          cyc(int'($urandom_range(0, 5)));
          data_ready = 1'b1;
          @(posedge clk);
          #1 m_clear();
          check_state("rnd.accept", 1'b0);
          check("rnd.accept.data", data_out, m_out);
          data_ready = 1'b0;
          cyc(1);
        end
      end else begin
        v = 4'($urandom_range(0, 15));
        enter_nib(v);
        check_state("rnd.enter", 1'b0);
      end
    end

    // reset while an offer is pending
    press(1'b0, 1'b1, 1'b0); m_clear();
    enter_nib(4'hB); enter_nib(4'hC);
    press(1'b0, 1'b0, 1'b1);
    check("rstoffer.pre", 32'(data_valid), 32'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("rstoffer.valid", 32'(data_valid), 32'h0);
    check("rstoffer.data", data_out, 32'h0);
    check("rstoffer.preview", preview, 32'h0);
    check("rstoffer.count", 32'(nibble_count), 32'h0);
    cyc(2);
    rst = 1'b1;
    m_clear();
    cyc(2);
    check_state("post.reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
